// File: rtl/shift_mult_ctrl.sv
// shift_mult_ctrl: unsigned N x N shift-and-add multiply sequencer.
// Drives an external combinational left shifter (sh_y = sh_a << sh_b) and
// does one conditional accumulate per multiplier bit. The fixed latency is
// N RUN cycles plus one DONE cycle. Start is accepted only in IDLE.
module shift_mult_ctrl #(
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   output logic [N-1:0]     sh_a,
   output logic [N-1:0]     sh_b,
   input  logic [2*N-1:0]   sh_y,
   output logic [2*N-1:0]   product,
   output logic             busy,
   output logic             done
);

   // Bit-index width. It is kept at least one bit wide so that N=1 still elaborates.
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_r, state_s;
   logic [IW-1:0]      idx_r, idx_s;
   logic [N-1:0]       mcand_r, mcand_s;
   logic [N-1:0]       mplier_r, mplier_s;
   logic [2*N-1:0]     acc_r, acc_s;
   logic [2*N-1:0]     product_r, product_s;
   logic               busy_r, busy_s;
   logic               done_r, done_s;
   logic [2*N-1:0]     term_s;
   logic [2*N-1:0]     sum_s;

   // Partial product: the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      term_s = '0;
      if (state_r == ST_RUN && mplier_r[idx_r]) begin
         term_s = sh_y;
      end else begin
         term_s = '0;
      end
      sum_s = acc_r + term_s;
   end

   // Shifter operands: the multiplicand and bit index in RUN, and zero in all other states.
   always_comb begin
      sh_a = '0;
      sh_b = '0;
      case (state_r)
         ST_RUN: begin
            sh_a = mcand_r;
            sh_b = N'(idx_r);
         end
         ST_IDLE, ST_DONE: begin
            sh_a = '0;
            sh_b = '0;
         end
         default: begin
            sh_a = '0;
            sh_b = '0;
         end
      endcase
   end

   // Next-state and datapath update logic. Outputs are decoded from the next state so that they can be registered.
   always_comb begin
      state_s   = state_r;
      idx_s     = idx_r;
      mcand_s   = mcand_r;
      mplier_s  = mplier_r;
      acc_s     = acc_r;
      product_s = product_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               mcand_s  = a;
               mplier_s = b;
               acc_s    = '0;
               idx_s    = '0;
               state_s  = ST_RUN;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_s = sum_s;
            if (idx_r == IDX_LAST) begin
               product_s = sum_s;
               state_s   = ST_DONE;
            end else begin
               idx_s     = idx_r + IW'(1);
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_DONE);
   end

   // State and datapath registers. A synchronous reset aborts any operation in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         idx_r     <= '0;
         mcand_r   <= '0;
         mplier_r  <= '0;
         acc_r     <= '0;
         product_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         mcand_r   <= mcand_s;
         mplier_r  <= mplier_s;
         acc_r     <= acc_s;
         product_r <= product_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign product = product_r;
   assign busy    = busy_r;
   assign done    = done_r;

endmodule

// File: doc/shift_mult_ctrl.md
Name: shift_mult_ctrl

Overview:
Sequencer that builds an unsigned N x N multiply out of the team's combinational left shifter (A<<B, 4-bit A and B, 8-bit result) plus an accumulator. The shifter stays an external instance in the parent. This block drives the shifter's operand and shift-amount inputs, reads back the shifted value, and does one conditional accumulate per multiplier bit. It sits between the lab top level (switch inputs, start button) and the shifter, and presents a start/busy/done handshake with a held product register.

Parameters:
N, 4, operand width. The product is 2N bits. Shifter interface widths follow N. The default must match the existing 4-bit shifter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse/level; sampled only in IDLE
a  input  N  multiplicand, sampled on accepted start
b  input  N  multiplier, sampled on accepted start
sh_a  output  N  to shifter A input (value to be shifted)
sh_b  output  N  to shifter B input (shift amount)
sh_y  input  2N  from shifter output, combinational (sh_a<<sh_b)
product  output  2N  registered result of last completed multiply
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when product updates

Behaviour:
- Reset (rst=1 at a rising edge), effective at that edge regardless of state:
  - state=IDLE; idx, mcand, mplier, acc and product all 0.
  - done=0, busy=0.
- sh_a and sh_b are combinational from state:
  - IDLE and DONE: sh_a=0, sh_b=0.
  - RUN: sh_a=mcand, sh_b=idx, with idx zero-extended to N bits.
- States:
  - IDLE: if start=1, latch mcand<=a, mplier<=b, acc<=0, idx<=0, and go to RUN. Otherwise hold.
  - RUN, once per cycle:
    - term = mplier[idx] ? sh_y : 0.
    - acc <= acc + term, truncated to 2N bits. The true product is < 2^(2N), so no overflow.
    - If idx==N-1: product <= acc + term, then go to DONE.
    - Else: idx <= idx+1.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency is fixed with no zero-skipping: start sampled at edge k → RUN during cycles k+1..k+N → DONE (done=1, new product visible) in cycle k+N+1 → IDLE in cycle k+N+2.
- busy=1 from cycle k+1 through cycle k+N+1 inclusive.
- A start asserted while busy=1 (RUN or DONE) is ignored and not queued. A start held high through DONE is accepted in the following IDLE cycle. The back-to-back period is therefore N+2 cycles.
- a and b may change freely after acceptance; only the latched copies are used.
- product holds its value between completions, and through an ignored start. Only rst or a new completion changes it.
- Reset mid-RUN aborts the operation. No done pulse occurs, and product clears to 0.
- sh_y is used only in RUN. Its value in other states is don't-care.
- The shift amount never exceeds N-1, so the shifter is never asked for an out-of-range shift.

Test Plan:
- Reset, then a=15, b=15, start for 1 cycle → busy high for N+1=5 cycles; done pulses once in cycle 5 after the start edge; product=225 (8'hE1) and holds.
- a=5, b=3 → product=15. a=0, b=9 → product=0. a=9, b=0 → product=0. Each completes in the same fixed 5-cycle latency.
- Start a=7, b=6; two cycles later pulse start with a=1, b=1 → second request ignored; product=42; exactly one done pulse.
- Start held high continuously with a=3, b=4 → completions every 6 cycles; product=12 each time; done pulses spaced 6 cycles apart.
- Start a=12, b=11, assert rst during the 2nd RUN cycle → next cycle state IDLE, busy=0, product=0, no done pulse. A following start with a=2, b=13 completes with product=26.
- Checker throughout RUN: sh_a equals the latched multiplicand and sh_b steps 0,1,2,3. Outside RUN, sh_a=sh_b=0.
